data_mem_responder: RTL

//   Data-memory responder serving the load/store requests that the RISC-V datapath issues.

---
 rtl/data_mem_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: RV32I data memory behind a valid/ready request/response handshake.
// Accesses commit after a fixed LATENCY; supports byte-lane stores and extended loads.
module data_mem_responder #(
   parameter int WIDTH       = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic [1:0]       dbg_state
);
   // Handshake: a request transfers on a cycle where req_valid & req_ready are both high;
   // a response transfers on a cycle where rsp_valid & rsp_ready are both high, and the
   // response payload is held stable from rsp_valid rising until that transfer.
   localparam int         AW   = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAST = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic             lat_we;
   logic [2:0]       lat_f3;
   logic [WIDTH-1:0] lat_addr;
   logic [WIDTH-1:0] lat_wdata;
   logic [WIDTH-1:0] mem [DEPTH_WORDS];

   logic             accept;
   logic             commit;
   logic             eff_we;
   logic [2:0]       eff_f3;
   logic [WIDTH-1:0] eff_addr;
   logic [WIDTH-1:0] eff_wdata;
   logic [AW-1:0]    word;
   logic [1:0]       lane;
   logic             oor;
   logic             misal;
   logic             bad_f3;
   logic             err;
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] rd_shift;
   logic [WIDTH-1:0] ld_data;
   logic [WIDTH-1:0] wr_data;
   logic [3:0]       be;

   assign accept    = req_valid & req_ready;
   assign dbg_state = state;

   // With zero latency the access commits on the accept edge, so it decodes the live inputs.
   always_comb begin
      eff_we    = lat_we;
      eff_f3    = lat_f3;
      eff_addr  = lat_addr;
      eff_wdata = lat_wdata;
      if (state == IDLE) begin
         eff_we    = req_we;
         eff_f3    = req_funct3;
         eff_addr  = req_addr;
         eff_wdata = req_wdata;
      end
      word   = eff_addr[AW+1:2];
      lane   = eff_addr[1:0];
      oor    = (eff_addr >> (AW + 2)) != '0;
      misal  = 1'b0;
      case (eff_f3[1:0])
         2'b01:   misal = lane[0];
         2'b10:   misal = (lane != 2'b00);
         default: misal = 1'b0;
      endcase
      if (eff_we) bad_f3 = (eff_f3 > 3'b010);
      else        bad_f3 = (eff_f3 == 3'b011) || (eff_f3[2:1] == 2'b11);
      err = oor | misal | bad_f3;

      rd_word  = mem[word];
      rd_shift = rd_word >> {lane, 3'b000};
      case (eff_f3)
         3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b010:  ld_data = rd_word;
         3'b100:  ld_data = {24'd0, rd_shift[7:0]};
         3'b101:  ld_data = {16'd0, rd_shift[15:0]};
         default: ld_data = '0;
      endcase

      case (eff_f3[1:0])
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      case (eff_f3[1:0])
         2'b00:   wr_data = {4{eff_wdata[7:0]}};
         2'b01:   wr_data = {2{eff_wdata[15:0]}};
         default: wr_data = eff_wdata;
      endcase

      commit = ((state == IDLE) && accept && (LATENCY == 0)) ||
               ((state == WAIT) && (cnt == LAST));
   end

   // Storage is deliberately not reset; reset only guarantees no commit is in flight.
   always_ff @(posedge clk) begin
      if (commit && eff_we && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[word][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         lat_we    <= 1'b0;
         lat_f3    <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  lat_we    <= req_we;
                  lat_f3    <= req_funct3;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  req_ready <= 1'b0;
                  cnt       <= '0;
                  state     <= WAIT;
                  if (commit) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= err;
                     rsp_rdata <= (eff_we || err) ? '0 : ld_data;
                  end
               end
            end
            WAIT: begin
               if (commit) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= err;
                  rsp_rdata <= (eff_we || err) ? '0 : ld_data;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule
